// File: rtl/rob_commit_pkg.sv
// Shared retirement definitions: commit state encoding, the "no exception"
// code and the MIPS delay-slot return offset.
package rob_commit_pkg;

   typedef enum logic [1:0] {
      ST_COMMIT     = 2'd0,
      ST_STORE_WAIT = 2'd1,
      ST_FLUSH      = 2'd2
   } state_e;

   localparam int unsigned EXC_NONE          = 0;
   localparam int unsigned DELAY_SLOT_OFFSET = 8;

endpackage

// File: rtl/rob_commit_branch_check.sv
// Combinational branch resolution for the retiring line: decides predictor
// update, misprediction and the fetch restart address.
module rob_commit_branch_check
   import rob_commit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              is_branch,
   input  logic              is_jump,
   input  logic              pred_taken,
   input  logic              resolved_taken,
   input  logic [ADDR_W-1:0] target,
   input  logic [ADDR_W-1:0] pc,
   output logic              bp_update,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc
);

   always_comb begin
      // Jumps are always resolved correctly at fetch, so they never train or flush.
      bp_update   = is_branch & ~is_jump;
      mispredict  = bp_update & (pred_taken ^ resolved_taken);
      redirect_pc = resolved_taken ? target : (pc + ADDR_W'(DELAY_SLOT_OFFSET));
   end

endmodule

// File: rtl/rob_commit.sv
// ROB retirement stage: retires the head line in program order, issuing the
// GPR write, store handshake, predictor update, flush/redirect and exceptions.
module rob_commit
   import rob_commit_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int GHR_W      = 5,
   parameter int EXC_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  head_valid,
   input  logic                  head_done,
   input  logic                  head_reg_write_en,
   input  logic [REG_ADDR_W-1:0] head_reg_write_addr,
   input  logic [DATA_W-1:0]     head_result,
   input  logic                  head_is_branch_taken,
   input  logic [GHR_W-1:0]      head_pht_index,
   input  logic                  head_is_inst_branch,
   input  logic                  head_is_inst_jump,
   input  logic                  head_is_inst_branch_taken,
   input  logic [ADDR_W-1:0]     head_inst_branch_target,
   input  logic                  head_mem_write_flag,
   input  logic [3:0]            head_mem_sel,
   input  logic [ADDR_W-1:0]     head_mem_addr,
   input  logic [DATA_W-1:0]     head_mem_write_data,
   input  logic [EXC_W-1:0]      head_exception_type,
   input  logic [ADDR_W-1:0]     head_pc,
   input  logic                  mem_ack,
   output logic                  head_pop,
   output logic                  rf_write_en,
   output logic [REG_ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0]     rf_write_data,
   output logic                  mem_req,
   output logic [3:0]            mem_sel,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  bp_update_en,
   output logic                  bp_update_taken,
   output logic [GHR_W-1:0]      bp_update_index,
   output logic                  flush,
   output logic [ADDR_W-1:0]     redirect_pc,
   output logic                  exc_en,
   output logic [EXC_W-1:0]      exc_type,
   output logic [ADDR_W-1:0]     exc_pc
);

   state_e                state_q, state_d;
   logic                  rf_write_en_q, rf_write_en_d;
   logic [REG_ADDR_W-1:0] rf_write_addr_q, rf_write_addr_d;
   logic [DATA_W-1:0]     rf_write_data_q, rf_write_data_d;
   logic                  mem_req_q, mem_req_d;
   logic [3:0]            mem_sel_q, mem_sel_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic                  bp_update_en_q, bp_update_en_d;
   logic                  bp_update_taken_q, bp_update_taken_d;
   logic [GHR_W-1:0]      bp_update_index_q, bp_update_index_d;
   logic                  flush_q, flush_d;
   logic [ADDR_W-1:0]     redirect_pc_q, redirect_pc_d;
   logic                  exc_en_q, exc_en_d;
   logic [EXC_W-1:0]      exc_type_q, exc_type_d;
   logic [ADDR_W-1:0]     exc_pc_q, exc_pc_d;

   logic                  ready;
   logic                  has_exc;
   logic                  br_update;
   logic                  br_mispredict;
   logic [ADDR_W-1:0]     br_redirect_pc;

   assign ready   = head_valid & head_done;
   assign has_exc = (head_exception_type != EXC_W'(EXC_NONE));

   rob_commit_branch_check #(
      .ADDR_W(ADDR_W)
   ) u_branch_check (
      .is_branch      (head_is_inst_branch),
      .is_jump        (head_is_inst_jump),
      .pred_taken     (head_is_branch_taken),
      .resolved_taken (head_is_inst_branch_taken),
      .target         (head_inst_branch_target),
      .pc             (head_pc),
      .bp_update      (br_update),
      .mispredict     (br_mispredict),
      .redirect_pc    (br_redirect_pc)
   );

   always_comb begin
      state_d           = state_q;
      head_pop          = 1'b0;
      rf_write_en_d     = 1'b0;
      rf_write_addr_d   = rf_write_addr_q;
      rf_write_data_d   = rf_write_data_q;
      mem_req_d         = 1'b0;
      mem_sel_d         = mem_sel_q;
      mem_addr_d        = mem_addr_q;
      mem_wdata_d       = mem_wdata_q;
      bp_update_en_d    = 1'b0;
      bp_update_taken_d = bp_update_taken_q;
      bp_update_index_d = bp_update_index_q;
      flush_d           = 1'b0;
      redirect_pc_d     = redirect_pc_q;
      exc_en_d          = 1'b0;
      exc_type_d        = exc_type_q;
      exc_pc_d          = exc_pc_q;

      unique case (state_q)
         ST_COMMIT: begin
            if (ready) begin
               if (has_exc) begin
                  head_pop   = 1'b1;
                  exc_en_d   = 1'b1;
                  exc_type_d = head_exception_type;
                  exc_pc_d   = head_pc;
                  flush_d    = 1'b1;
                  state_d    = ST_FLUSH;
               end else if (head_mem_write_flag) begin
                  // The store stays at the head until memory accepts it.
                  mem_req_d   = 1'b1;
                  mem_sel_d   = head_mem_sel;
                  mem_addr_d  = head_mem_addr;
                  mem_wdata_d = head_mem_write_data;
                  state_d     = ST_STORE_WAIT;
               end else begin
                  head_pop        = 1'b1;
                  rf_write_en_d   = head_reg_write_en & (head_reg_write_addr != '0);
                  rf_write_addr_d = head_reg_write_addr;
                  rf_write_data_d = head_result;
                  if (br_update) begin
                     bp_update_en_d    = 1'b1;
                     bp_update_taken_d = head_is_inst_branch_taken;
                     bp_update_index_d = head_pht_index;
                  end
                  if (br_mispredict) begin
                     flush_d       = 1'b1;
                     redirect_pc_d = br_redirect_pc;
                     state_d       = ST_FLUSH;
                  end
               end
            end
         end
         ST_STORE_WAIT: begin
            mem_req_d = ~mem_ack;
            if (mem_ack) begin
               head_pop = 1'b1;
               state_d  = ST_COMMIT;
            end
         end
         ST_FLUSH: begin
            state_d = ST_COMMIT;
         end
         default: begin
            state_d = ST_COMMIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q           <= ST_COMMIT;
         rf_write_en_q     <= 1'b0;
         rf_write_addr_q   <= '0;
         rf_write_data_q   <= '0;
         mem_req_q         <= 1'b0;
         mem_sel_q         <= '0;
         mem_addr_q        <= '0;
         mem_wdata_q       <= '0;
         bp_update_en_q    <= 1'b0;
         bp_update_taken_q <= 1'b0;
         bp_update_index_q <= '0;
         flush_q           <= 1'b0;
         redirect_pc_q     <= '0;
         exc_en_q          <= 1'b0;
         exc_type_q        <= '0;
         exc_pc_q          <= '0;
      end else begin
         state_q           <= state_d;
         rf_write_en_q     <= rf_write_en_d;
         rf_write_addr_q   <= rf_write_addr_d;
         rf_write_data_q   <= rf_write_data_d;
         mem_req_q         <= mem_req_d;
         mem_sel_q         <= mem_sel_d;
         mem_addr_q        <= mem_addr_d;
         mem_wdata_q       <= mem_wdata_d;
         bp_update_en_q    <= bp_update_en_d;
         bp_update_taken_q <= bp_update_taken_d;
         bp_update_index_q <= bp_update_index_d;
         flush_q           <= flush_d;
         redirect_pc_q     <= redirect_pc_d;
         exc_en_q          <= exc_en_d;
         exc_type_q        <= exc_type_d;
         exc_pc_q          <= exc_pc_d;
      end
   end

   assign rf_write_en     = rf_write_en_q;
   assign rf_write_addr   = rf_write_addr_q;
   assign rf_write_data   = rf_write_data_q;
   assign mem_req         = mem_req_q;
   assign mem_sel         = mem_sel_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign bp_update_en    = bp_update_en_q;
   assign bp_update_taken = bp_update_taken_q;
   assign bp_update_index = bp_update_index_q;
   assign flush           = flush_q;
   assign redirect_pc     = redirect_pc_q;
   assign exc_en          = exc_en_q;
   assign exc_type        = exc_type_q;
   assign exc_pc          = exc_pc_q;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed retire scenarios with literal expectations,
// plus a per-cycle comparison against a behavioural retirement model.
module tb_rob_commit;

   logic        clk;
   logic        rst;
   logic        head_valid, head_done, head_reg_write_en;
   logic [4:0]  head_reg_write_addr;
   logic [31:0] head_result;
   logic        head_is_branch_taken;
   logic [4:0]  head_pht_index;
   logic        head_is_inst_branch, head_is_inst_jump, head_is_inst_branch_taken;
   logic [31:0] head_inst_branch_target;
   logic        head_mem_write_flag;
   logic [3:0]  head_mem_sel;
   logic [31:0] head_mem_addr, head_mem_write_data;
   logic [7:0]  head_exception_type;
   logic [31:0] head_pc;
   logic        mem_ack;
   logic        head_pop, rf_write_en;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic        mem_req;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr, mem_wdata;
   logic        bp_update_en, bp_update_taken;
   logic [4:0]  bp_update_index;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        exc_en;
   logic [7:0]  exc_type;
   logic [31:0] exc_pc;

   int checks = 0;
   int errors = 0;

   rob_commit dut (
      .clk(clk), .rst(rst),
      .head_valid(head_valid), .head_done(head_done),
      .head_reg_write_en(head_reg_write_en), .head_reg_write_addr(head_reg_write_addr),
      .head_result(head_result), .head_is_branch_taken(head_is_branch_taken),
      .head_pht_index(head_pht_index), .head_is_inst_branch(head_is_inst_branch),
      .head_is_inst_jump(head_is_inst_jump),
      .head_is_inst_branch_taken(head_is_inst_branch_taken),
      .head_inst_branch_target(head_inst_branch_target),
      .head_mem_write_flag(head_mem_write_flag), .head_mem_sel(head_mem_sel),
      .head_mem_addr(head_mem_addr), .head_mem_write_data(head_mem_write_data),
      .head_exception_type(head_exception_type), .head_pc(head_pc),
      .mem_ack(mem_ack), .head_pop(head_pop),
      .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .bp_update_en(bp_update_en), .bp_update_taken(bp_update_taken),
      .bp_update_index(bp_update_index), .flush(flush), .redirect_pc(redirect_pc),
      .exc_en(exc_en), .exc_type(exc_type), .exc_pc(exc_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what each output must show in the cycle after an edge.
   bit          m_store_pending = 0;
   bit          m_flush_cycle   = 0;
   bit          e_rf_we = 0, e_mem_req = 0, e_bp_en = 0, e_flush = 0, e_exc = 0;
   bit          e_bp_taken = 0, e_redirect_valid = 0;
   logic [4:0]  e_rf_addr = '0, e_bp_index = '0;
   logic [31:0] e_rf_data = '0, e_mem_addr = '0, e_mem_wdata = '0, e_redirect = '0, e_exc_pc = '0;
   logic [3:0]  e_mem_sel = '0;
   logic [7:0]  e_exc_type = '0;

   always @(posedge clk) begin
      bit ready;
      ready = head_valid && head_done;
      e_rf_we = 0; e_bp_en = 0; e_flush = 0; e_exc = 0; e_redirect_valid = 0;
      if (!rst) begin
         m_store_pending = 0; m_flush_cycle = 0; e_mem_req = 0;
      end else if (m_flush_cycle) begin
         m_flush_cycle = 0;
      end else if (m_store_pending) begin
         if (mem_ack) begin
            m_store_pending = 0; e_mem_req = 0;
         end
      end else if (ready) begin
         if (head_exception_type != 0) begin
            e_exc = 1; e_exc_type = head_exception_type; e_exc_pc = head_pc;
            e_flush = 1; m_flush_cycle = 1;
         end else if (head_mem_write_flag) begin
            m_store_pending = 1; e_mem_req = 1;
            e_mem_sel = head_mem_sel; e_mem_addr = head_mem_addr; e_mem_wdata = head_mem_write_data;
         end else begin
            e_rf_we = head_reg_write_en && (head_reg_write_addr != 0);
            e_rf_addr = head_reg_write_addr; e_rf_data = head_result;
            if (head_is_inst_branch && !head_is_inst_jump) begin
               e_bp_en = 1; e_bp_taken = head_is_inst_branch_taken; e_bp_index = head_pht_index;
               if (head_is_branch_taken != head_is_inst_branch_taken) begin
                  e_flush = 1; m_flush_cycle = 1; e_redirect_valid = 1;
                  e_redirect = head_is_inst_branch_taken ? head_inst_branch_target
                                                        : head_pc + 32'd8;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      bit exp_pop;
      if (rst === 1'b1) begin
         if (m_flush_cycle) exp_pop = 0;
         else if (m_store_pending) exp_pop = mem_ack;
         else exp_pop = head_valid && head_done &&
                        ((head_exception_type != 0) || !head_mem_write_flag);
         chk("m_head_pop", head_pop, exp_pop);
         chk("m_rf_write_en", rf_write_en, e_rf_we);
         chk("m_mem_req", mem_req, e_mem_req);
         chk("m_bp_update_en", bp_update_en, e_bp_en);
         chk("m_flush", flush, e_flush);
         chk("m_exc_en", exc_en, e_exc);
         if (e_rf_we) begin
            chk("m_rf_addr", rf_write_addr, e_rf_addr);
            chk("m_rf_data", rf_write_data, e_rf_data);
         end
         if (e_mem_req) begin
            chk("m_mem_sel", mem_sel, e_mem_sel);
            chk("m_mem_addr", mem_addr, e_mem_addr);
            chk("m_mem_wdata", mem_wdata, e_mem_wdata);
         end
         if (e_bp_en) begin
            chk("m_bp_taken", bp_update_taken, e_bp_taken);
            chk("m_bp_index", bp_update_index, e_bp_index);
         end
         if (e_redirect_valid) chk("m_redirect_pc", redirect_pc, e_redirect);
         if (e_exc) begin
            chk("m_exc_type", exc_type, e_exc_type);
            chk("m_exc_pc", exc_pc, e_exc_pc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_head();
      head_valid = 0; head_done = 0; head_reg_write_en = 0; head_reg_write_addr = '0;
      head_result = '0; head_is_branch_taken = 0; head_pht_index = '0;
      head_is_inst_branch = 0; head_is_inst_jump = 0; head_is_inst_branch_taken = 0;
      head_inst_branch_target = '0; head_mem_write_flag = 0; head_mem_sel = '0;
      head_mem_addr = '0; head_mem_write_data = '0; head_exception_type = '0; head_pc = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_outputs_zero"},
          {rf_write_en, mem_req, bp_update_en, bp_update_taken, flush, exc_en, head_pop},
          64'd0);
      chk({tag, "_payload_zero"},
          {rf_write_addr, rf_write_data, mem_sel, bp_update_index, exc_type},
          64'd0);
      chk({tag, "_addr_zero"}, {mem_addr, mem_wdata}, 64'd0);
      chk({tag, "_pc_zero"}, {redirect_pc, exc_pc}, 64'd0);
   endtask

   task automatic branch_line(input logic [31:0] pc, input bit pred, input bit res,
                              input logic [31:0] tgt, input bit jump);
      clear_head();
      head_valid = 1; head_done = 1; head_pc = pc; head_pht_index = 5'h0A;
      head_is_inst_branch = ~jump; head_is_inst_jump = jump;
      head_is_branch_taken = pred; head_is_inst_branch_taken = res;
      head_inst_branch_target = tgt;
   endtask

   initial begin
      int req_cycles;
      int pops;
      rst = 0; mem_ack = 0;
      clear_head();
      repeat (3) step();
      #1 check_all_zero("reset");
      rst = 1;
      step();

      // ALU retire
      head_valid = 1; head_done = 1; head_reg_write_en = 1;
      head_reg_write_addr = 5'd3; head_result = 32'hDEADBEEF;
      #1 chk("alu_pop", head_pop, 1);
      step();
      clear_head();
      chk("alu_rf_we", rf_write_en, 1);
      chk("alu_rf_addr", rf_write_addr, 3);
      chk("alu_rf_data", rf_write_data, 32'hDEADBEEF);
      step();
      chk("alu_rf_we_pulse", rf_write_en, 0);

      // Store with ack three cycles after the request appears
      head_valid = 1; head_done = 1; head_mem_write_flag = 1; head_mem_sel = 4'hF;
      head_mem_addr = 32'h80001000; head_mem_write_data = 32'h1234;
      head_reg_write_en = 1; head_reg_write_addr = 5'd9;
      #1 chk("st_no_early_pop", head_pop, 0);
      req_cycles = 0; pops = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (c == 3) mem_ack = 1;
         if (c == 4) begin mem_ack = 0; clear_head(); end
         #1;
         if (mem_req) begin
            req_cycles++;
            chk("st_payload", {mem_sel, mem_addr, mem_wdata[27:0]}, {4'hF, 32'h80001000, 28'h1234});
         end
         if (head_pop) begin
            pops++;
            chk("st_pop_in_ack_cycle", c, 3);
         end
         chk("st_no_rf_write", rf_write_en, 0);
      end
      chk("st_req_cycles", req_cycles, 4);
      chk("st_pops", pops, 1);

      // Not-taken mispredict, then a ready head during the flush cycle
      branch_line(32'hBFC00100, 1, 0, 32'h12345678, 0);
      #1 chk("mp_pop", head_pop, 1);
      step();
      chk("mp_bp_en", bp_update_en, 1);
      chk("mp_bp_taken", bp_update_taken, 0);
      chk("mp_bp_index", bp_update_index, 5'h0A);
      chk("mp_flush", flush, 1);
      chk("mp_redirect", redirect_pc, 32'hBFC00108);
      clear_head();
      head_valid = 1; head_done = 1; head_reg_write_en = 1; head_reg_write_addr = 5'd7;
      head_result = 32'h55;
      #1 chk("mp_no_pop_in_flush", head_pop, 0);
      step();
      chk("mp_flush_pulse", flush, 0);
      chk("mp_no_rf_in_flush", rf_write_en, 0);
      clear_head();
      step();

      // Taken mispredict, wrapping not-taken redirect, correct prediction, jump
      branch_line(32'hFFFFFFF0, 0, 1, 32'h00000040, 0);
      step();
      chk("tk_redirect", redirect_pc, 32'h40);
      chk("tk_bp_taken", bp_update_taken, 1);
      clear_head();
      step();
      branch_line(32'hFFFFFFFC, 1, 0, 32'h00000040, 0);
      step();
      chk("wrap_redirect", redirect_pc, 32'h00000004);
      clear_head();
      step();
      branch_line(32'h1000, 1, 1, 32'h2000, 0);
      step();
      chk("ok_pred_no_flush", {bp_update_en, flush}, 2'b10);
      branch_line(32'h1008, 0, 1, 32'h3000, 1);
      step();
      chk("jump_no_update", {bp_update_en, flush}, 2'b00);
      clear_head();
      step();

      // Exception on a line that would also write a GPR
      head_valid = 1; head_done = 1; head_reg_write_en = 1; head_reg_write_addr = 5'd5;
      head_exception_type = 8'h04; head_pc = 32'h400;
      #1 chk("exc_pop", head_pop, 1);
      step();
      clear_head();
      chk("exc_en", exc_en, 1);
      chk("exc_type", exc_type, 8'h04);
      chk("exc_pc", exc_pc, 32'h400);
      chk("exc_flush", flush, 1);
      chk("exc_no_rf", rf_write_en, 0);
      step();
      chk("exc_pulse", {exc_en, flush}, 2'b00);

      // Reset while a store waits, then a stray ack
      head_valid = 1; head_done = 1; head_mem_write_flag = 1; head_mem_sel = 4'h3;
      head_mem_addr = 32'h80002000; head_mem_write_data = 32'hCAFE;
      step();
      chk("rs_req_up", mem_req, 1);
      step();
      rst = 0;
      step();
      clear_head();
      rst = 1;
      #1 check_all_zero("rs");
      mem_ack = 1;
      #1 chk("rs_ack_no_pop", head_pop, 0);
      step();
      mem_ack = 0;
      #1 check_all_zero("rs_after_ack");

      // x0 destination, then a head that is valid but not done
      head_valid = 1; head_done = 1; head_reg_write_en = 1; head_reg_write_addr = 5'd0;
      head_result = 32'hFFFF;
      #1 chk("x0_pop", head_pop, 1);
      step();
      chk("x0_no_rf", rf_write_en, 0);
      head_done = 0; head_reg_write_addr = 5'd4;
      for (int c = 0; c < 5; c++) begin
         #1 chk("nd_no_pop", head_pop, 0);
         step();
         chk("nd_no_rf", rf_write_en, 0);
      end
      clear_head();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Retirement end of the reorder buffer. Reads the line at the ROB head and retires it in program order.
- Per retired line it performs:
  - the architectural register-file write;
  - store issue to the data-memory port, with a request/ack handshake;
  - branch predictor update;
  - misprediction flush with PC redirect;
  - precise exception signalling.
- Sits between the ROB storage array (head line fields as inputs) and the register file, memory port, branch predictor and CP0.

Parameters:
- DATA_W, 32, data/result width
- ADDR_W, 32, address/PC width
- REG_ADDR_W, 5, architectural register index width
- GHR_W, 5, PHT index width
- EXC_W, 8, exception type width; zero means no exception

Ports:
- clk  in  1  clock
- rst  in  1  reset
- head_valid  in  1  head line occupied
- head_done  in  1  head line executed
- head_reg_write_en  in  1  line writes a GPR
- head_reg_write_addr  in  REG_ADDR_W  destination GPR
- head_result  in  DATA_W  result value
- head_is_branch_taken  in  1  predicted direction
- head_pht_index  in  GHR_W  PHT index used at prediction
- head_is_inst_branch  in  1  conditional branch
- head_is_inst_jump  in  1  jump
- head_is_inst_branch_taken  in  1  resolved direction
- head_inst_branch_target  in  ADDR_W  resolved target
- head_mem_write_flag  in  1  store
- head_mem_sel  in  4  byte enables
- head_mem_addr  in  ADDR_W  store address
- head_mem_write_data  in  DATA_W  store data
- head_exception_type  in  EXC_W  exception code
- head_pc  in  ADDR_W  PC of line
- mem_ack  in  1  store accepted
- head_pop  out  1  advance ROB head (combinational)
- rf_write_en  out  1  GPR write strobe
- rf_write_addr  out  REG_ADDR_W  GPR index
- rf_write_data  out  DATA_W  GPR data
- mem_req  out  1  store request
- mem_sel  out  4  byte enables
- mem_addr  out  ADDR_W  store address
- mem_wdata  out  DATA_W  store data
- bp_update_en  out  1  predictor update strobe
- bp_update_taken  out  1  resolved direction
- bp_update_index  out  GHR_W  PHT index
- flush  out  1  squash ROB and front end
- redirect_pc  out  ADDR_W  fetch restart PC
- exc_en  out  1  exception strobe to CP0
- exc_type  out  EXC_W  exception code
- exc_pc  out  ADDR_W  faulting PC

Behaviour:
- Reset (rst low at posedge): state COMMIT. All registered outputs are 0. A mem_req in flight is dropped, and any late mem_ack is ignored.
- States: COMMIT, STORE_WAIT, FLUSH.
- Ready = head_valid & head_done. In COMMIT with ready low: nothing happens and all strobes stay 0.
- COMMIT, ready, head_exception_type != 0 (highest priority):
  - head_pop = 1.
  - Next cycle: exc_en = 1, exc_type and exc_pc latched, flush = 1.
  - No GPR write, no store, no predictor update.
  - Next state FLUSH.
- COMMIT, ready, head_mem_write_flag:
  - head_pop = 0.
  - Next cycle: mem_req = 1, with mem_sel/mem_addr/mem_wdata latched.
  - Next state STORE_WAIT.
- COMMIT, ready, otherwise:
  - head_pop = 1.
  - Next cycle: rf_write_en = head_reg_write_en & (addr != 0), with addr and data latched.
- Branch handling in the otherwise case:
  - On a branch: bp_update_en = 1, bp_update_taken = resolved direction, bp_update_index = head_pht_index.
  - Mispredict = branch & (predicted != resolved).
  - On a jump: no predictor update and never a mispredict.
  - On a mispredict: flush = 1 next cycle. redirect_pc = target if resolved taken, else head_pc + 8 (delay slot). Next state FLUSH.
- STORE_WAIT:
  - mem_req and its payload are held stable until mem_ack is sampled high.
  - In the mem_ack cycle: head_pop = 1. mem_req drops at the following edge. Next state COMMIT.
  - Stores never write a GPR.
- FLUSH:
  - Lasts exactly one cycle. head_pop = 0 and no strobes are asserted.
  - Returns to COMMIT. The ROB is cleared externally during this cycle.
- Strobe timing:
  - rf_write_en, bp_update_en, exc_en and flush are single-cycle pulses, each one cycle after the corresponding pop.
  - Throughput is at most one retire per cycle.
- Redirect arithmetic: redirect_pc is computed mod 2^ADDR_W, so head_pc + 8 wraps without error.
- mem_ack while not in STORE_WAIT is ignored.

Decomposition:
- Shared package (existing bus/branch headers): state encoding constants, the EXC_NONE = 0 constant, and the delay-slot offset constant (8).
- One natural sub-module, rob_commit_branch_check: combinational mispredict/redirect computation.
- Everything else stays inline.

Test Plan:
- ALU retire: head ready, reg_write_en = 1, addr = 3, result = 0xDEADBEEF → head_pop pulse; next cycle rf_write_en = 1, addr 3, data 0xDEADBEEF.
- Store handshake: addr 0x80001000, data 0x1234, sel 0xF, mem_ack delayed 3 cycles → mem_req high 4 cycles with stable payload; head_pop only in the ack cycle; no rf write.
- Mispredict not-taken: pc 0xBFC00100, predicted 1, resolved 0 → bp_update_taken = 0, flush = 1, redirect_pc = 0xBFC00108; the following cycle shows no pop even with head ready.
- Exception: exception_type = 0x04, reg_write_en = 1, pc 0x400 → exc_en = 1, exc_type 0x04, exc_pc 0x400, flush = 1; rf_write_en stays 0.
- Reset mid-store: rst low during STORE_WAIT, then mem_ack after release → mem_req 0, no head_pop, all outputs 0.
- x0 write and not-done head: addr 0 → no rf_write_en; head_done = 0 → no head_pop for 5 cycles.
